// File: rtl/xm23_mem_stage.sv
// ----------------------------------------------------------------------------
// xm23_mem_stage
//
// Data-memory access stage of the XM23 pipeline. Takes one LD/ST/LDR/STR
// request at a time from the execute stage, forms the effective address
// (pre/post increment/decrement, signed offset), drives the synchronous data
// RAM and returns the load result and any base-register update to the
// register-file writeback path. The pipeline is stalled while a request is
// in flight.
//
// Ports
//   clk, reset                 pipeline clock, async active-low reset
//   req_valid / req_ready      request handshake from the execute stage
//   is_store, wb               store select, byte (1) / word (0) access
//   prpo, dec, inc             addressing mode (prpo 1 = pre, 0 = post)
//   base_reg, base_val         base register number and value
//   offset                     sign-extended LDR/STR offset (0 for LD/ST)
//   store_val                  store source value
//   dst_reg, dst_old           load destination and its current value
//   flush                      branch-mispredict flush
//   dram_addr/data/byteena/wren, dram_q   synchronous data RAM port
//   ld_valid, ld_reg, ld_data  load writeback strobe
//   bupd_valid, bupd_reg, bupd_data       base-register update strobe
//   stall                      req_valid & ~req_ready
//   align_err                  word access with odd effective address
//
// Parameter
//   RAM_LATENCY  cycles from dram_addr to valid dram_q (1..4)
// ----------------------------------------------------------------------------
//
// state  | meaning
// -------+----------------------------------------------------------------
// IDLE   | no request in flight, ready to accept
// ACCESS | RAM address/data/enables presented; store writes here
// WAIT   | load waiting for RAM read data (RAM_LATENCY cycles)
// DONE   | load result presented on ld_*; next request may be accepted
//
module xm23_mem_stage #(
  parameter int unsigned RAM_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        is_store,
  input  logic        wb,
  input  logic        prpo,
  input  logic        dec,
  input  logic        inc,
  input  logic [2:0]  base_reg,
  input  logic [15:0] base_val,
  input  logic [15:0] offset,
  input  logic [15:0] store_val,
  input  logic [2:0]  dst_reg,
  input  logic [15:0] dst_old,
  input  logic        flush,
  output logic [14:0] dram_addr,
  output logic [15:0] dram_data,
  output logic [1:0]  dram_byteena,
  output logic        dram_wren,
  input  logic [15:0] dram_q,
  output logic        ld_valid,
  output logic [2:0]  ld_reg,
  output logic [15:0] ld_data,
  output logic        bupd_valid,
  output logic [2:0]  bupd_reg,
  output logic [15:0] bupd_data,
  output logic        stall,
  output logic        align_err
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_WAIT   = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  // WAIT lasts RAM_LATENCY cycles: counter loaded in ACCESS, exits at zero.
  localparam logic [1:0] WAIT_INIT = 2'(RAM_LATENCY - 1);

  state_t      state_q, state_d;
  logic [1:0]  wait_cnt_q;
  logic        wait_tc;
  logic        accept;
  logic        ld_capture;

  logic        st_store_q;
  logic        st_wb_q;
  logic        st_hi_q;
  logic [2:0]  st_dst_q;
  logic [15:0] st_dst_old_q;
  logic        flush_seen_q;
  logic        ld_valid_q;

  logic [15:0] step;
  logic [15:0] adjusted;
  logic [15:0] ea;

  // --------------------------------------------------------------------------
  // Effective address (all sums wrap modulo 2^16)
  // --------------------------------------------------------------------------
  always_comb begin
    step = wb ? 16'd1 : 16'd2;
    if (inc) begin
      adjusted = base_val + step;
    end else if (dec) begin
      adjusted = base_val - step;
    end else begin
      adjusted = base_val;
    end
    ea = (prpo ? adjusted : base_val) + offset;
  end

  // DONE also accepts so that loads sustain one per 2+RAM_LATENCY cycles.
  assign req_ready = (state_q == S_IDLE) || (state_q == S_DONE);
  assign stall     = req_valid & ~req_ready;
  assign accept    = req_valid & req_ready & ~flush;
  assign wait_tc   = (wait_cnt_q == 2'd0);

  // A flush coinciding with the writeback strobe still squashes it.
  assign ld_valid  = ld_valid_q & ~flush;

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    ld_capture = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) state_d = S_ACCESS;
      end
      S_ACCESS: begin
        state_d = st_store_q ? S_IDLE : S_WAIT;
      end
      S_WAIT: begin
        if (wait_tc) begin
          state_d    = S_DONE;
          ld_capture = 1'b1;
        end
      end
      S_DONE: begin
        state_d = accept ? S_ACCESS : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wait_cnt_q <= 2'd0;
    end else if (state_q == S_ACCESS) begin
      wait_cnt_q <= WAIT_INIT;
    end else if (state_q == S_WAIT && !wait_tc) begin
      wait_cnt_q <= wait_cnt_q - 2'd1;
    end
  end

  // Remember a flush seen while a load is still in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      flush_seen_q <= 1'b0;
    end else if (accept) begin
      flush_seen_q <= 1'b0;
    end else if (flush && !st_store_q &&
                 (state_q == S_ACCESS || state_q == S_WAIT)) begin
      flush_seen_q <= 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Request latch, RAM port and writeback registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st_store_q   <= 1'b0;
      st_wb_q      <= 1'b0;
      st_hi_q      <= 1'b0;
      st_dst_q     <= 3'd0;
      st_dst_old_q <= 16'd0;
      dram_addr    <= 15'd0;
      dram_data    <= 16'd0;
      dram_byteena <= 2'b00;
      dram_wren    <= 1'b0;
      bupd_valid   <= 1'b0;
      bupd_reg     <= 3'd0;
      bupd_data    <= 16'd0;
      align_err    <= 1'b0;
      ld_valid_q   <= 1'b0;
      ld_reg       <= 3'd0;
      ld_data      <= 16'd0;
    end else begin
      dram_wren  <= 1'b0;
      bupd_valid <= 1'b0;
      align_err  <= 1'b0;
      ld_valid_q <= 1'b0;

      if (accept) begin
        st_store_q   <= is_store;
        st_wb_q      <= wb;
        st_hi_q      <= ea[0];
        st_dst_q     <= dst_reg;
        st_dst_old_q <= dst_old;
        // Address stays on the port through WAIT for multi-cycle RAMs.
        dram_addr    <= ea[15:1];
        dram_byteena <= wb ? (ea[0] ? 2'b10 : 2'b01) : 2'b11;
        dram_data    <= wb ? {store_val[7:0], store_val[7:0]} : store_val;
        dram_wren    <= is_store;
        bupd_valid   <= inc | dec;
        if (inc | dec) begin
          bupd_reg  <= base_reg;
          bupd_data <= adjusted;
        end
        // Odd word address is flagged; the access proceeds with bit0 dropped.
        align_err    <= ~wb & ea[0];
      end

      if (ld_capture) begin
        ld_valid_q <= ~flush_seen_q & ~flush;
        ld_reg     <= st_dst_q;
        ld_data    <= st_wb_q ?
                      {st_dst_old_q[15:8], (st_hi_q ? dram_q[15:8] : dram_q[7:0])} :
                      dram_q;
      end
    end
  end

endmodule
